// File: rtl/output_layer_mac.sv
// Ten-neuron output-layer multiply-accumulate.
// Each accepted sample x_in is multiplied by ten signed weights from w_bus and
// added into ten saturating accumulators. After N_INPUTS accepted samples the
// final sums are loaded into cell0..cell9, sat_flag reports whether any
// accumulator clamped during the frame, and cell_outputvalid pulses for one
// cycle while the accumulators clear.
module output_layer_mac #(
  parameter int N_INPUTS = 64,
  parameter int ACC_W    = 26
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             Input_Valid,
  input  logic [7:0]       x_in,
  input  logic [79:0]      w_bus,
  output logic             in_ready,
  output logic [ACC_W-1:0] cell0,
  output logic [ACC_W-1:0] cell1,
  output logic [ACC_W-1:0] cell2,
  output logic [ACC_W-1:0] cell3,
  output logic [ACC_W-1:0] cell4,
  output logic [ACC_W-1:0] cell5,
  output logic [ACC_W-1:0] cell6,
  output logic [ACC_W-1:0] cell7,
  output logic [ACC_W-1:0] cell8,
  output logic [ACC_W-1:0] cell9,
  output logic             cell_outputvalid,
  output logic             sat_flag
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [ACC_W-1:0] r_acc  [10];
  logic [ACC_W-1:0] r_cell [10];
  logic             r_valid;
  logic             r_sat_flag;
  logic             r_sat_track;
  logic             r_in_ready;

  logic [ACC_W-1:0] w_sum [10];
  logic [9:0]       w_ovf;
  logic             w_accept;
  logic             w_last;

  // in_ready is a flop that mirrors "state is not DONE", so a sample is taken
  // only when the FSM can use it.
  assign w_accept = Input_Valid && r_in_ready;
  assign w_last   = (r_count == CNT_W'(N_INPUTS - 1));

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_neuron
      logic signed [15:0]    w_prod;
      logic signed [ACC_W-1:0] w_prod_ext;
      logic        [ACC_W:0] w_wide;

      assign w_prod     = $signed(x_in) * $signed(w_bus[8*gi +: 8]);
      assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
      // One extra bit of headroom: disagreement of the top two bits means the
      // true sum left the ACC_W-bit signed range.
      assign w_wide     = {r_acc[gi][ACC_W-1], r_acc[gi]} + {w_prod_ext[ACC_W-1], w_prod_ext};
      assign w_ovf[gi]  = w_wide[ACC_W] ^ w_wide[ACC_W-1];

      // Clamp toward the sign of the true (wide) sum on overflow.
      always_comb begin
        w_sum[gi] = w_wide[ACC_W-1:0];
        if (w_ovf[gi]) begin
          if (w_wide[ACC_W]) begin
            w_sum[gi] = {1'b1, {(ACC_W-1){1'b0}}};
          end else begin
            w_sum[gi] = {1'b0, {(ACC_W-1){1'b1}}};
          end
        end
      end
    end
  endgenerate

  // Frame FSM: accumulate samples, publish results on the last one, then spend
  // one DONE cycle pulsing valid and clearing the accumulators.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_sat_flag  <= 1'b0;
      r_sat_track <= 1'b0;
      r_in_ready  <= 1'b1;
      for (int i = 0; i < 10; i++) begin
        r_acc[i]  <= '0;
        r_cell[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            for (int i = 0; i < 10; i++) begin
              r_acc[i] <= w_sum[i];
            end
            r_sat_track <= r_sat_track | (|w_ovf);
            if (w_last) begin
              for (int i = 0; i < 10; i++) begin
                r_cell[i] <= w_sum[i];
              end
              r_sat_flag <= r_sat_track | (|w_ovf);
              r_valid    <= 1'b1;
              r_in_ready <= 1'b0;
              r_count    <= '0;
              r_state    <= S_DONE;
            end else begin
              r_count <= r_count + 1'b1;
              r_state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          for (int i = 0; i < 10; i++) begin
            r_acc[i] <= '0;
          end
          r_sat_track <= 1'b0;
          r_count     <= '0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready         = r_in_ready;
  assign cell_outputvalid = r_valid;
  assign sat_flag         = r_sat_flag;
  assign cell0            = r_cell[0];
  assign cell1            = r_cell[1];
  assign cell2            = r_cell[2];
  assign cell3            = r_cell[3];
  assign cell4            = r_cell[4];
  assign cell5            = r_cell[5];
  assign cell6            = r_cell[6];
  assign cell7            = r_cell[7];
  assign cell8            = r_cell[8];
  assign cell9            = r_cell[9];

endmodule
